// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path: the transmitter state
// encoding, the legal range of data bits per frame and the parity type codes.
// Optional feature macro: UART_TX_BREAK_EN adds the BREAK and MAB states.
package uart_pkg;

    localparam int DATA_W_MIN = 5;
    localparam int DATA_W_MAX = 9;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4,
        TX_BREAK  = 3'd5,
        TX_MAB    = 3'd6
    } tx_state_e;
`else
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;
`endif

endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if
// Ready/valid word handshake between the host-side byte source and the
// UART transmitter.
//   data  : parallel word to send (DATA_W bits)
//   valid : data is valid, held by the source until accepted
//   ready : transmitter can take a word this cycle
// Modports: master = word source, slave = transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt
// Loadable down-counter that marks the last clock of every bit period.
//   i_clk, i_rst : clock and synchronous active-high reset
//   i_load       : reload the counter with i_load_val this edge
//   i_load_val   : bit period minus one, in clock cycles
//   i_en         : strobe is only meaningful while a frame is running
//   o_bit_end    : one-cycle strobe in the final clock of a bit period
module uart_baud_cnt #(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_bit_end
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    // Counting from N down to 0 gives N+1 clocks per bit; the owner reloads
    // in the same cycle that bit_end fires so consecutive bits abut.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_bit_end = i_en && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// Parametrised UART transmitter: START, DATA_W data bits LSB first, optional
// parity, one or two STOP bits, with a ready/valid word handshake that allows
// back-to-back frames without an idle gap.
// Optional feature macro: UART_TX_BREAK_EN (adds i_break, BREAK and MAB states).
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_baud_div          : bit period minus one (0 is treated as 1)
//   i_par_en, i_par_typ : parity enable, parity type (0 even, 1 odd)
//   i_stop2             : two stop bits when set
//   i_break             : hold the line low while idle (macro builds only)
//   bus                 : word handshake (slave side)
//   o_tx                : registered serial line, idle high
//   o_busy              : frame or break in progress
//   o_done              : pulse in the last clock of the final stop bit
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DIV_W-1:0] i_baud_div,
    input  logic             i_par_en,
    input  logic             i_par_typ,
    input  logic             i_stop2,
`ifdef UART_TX_BREAK_EN
    input  logic             i_break,
`endif
    uart_tx_frame_if.slave   bus,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CNT_W = $clog2(DATA_W_MAX + 1);

    localparam logic [2:0] ST_IDLE   = TX_IDLE;
    localparam logic [2:0] ST_START  = TX_START;
    localparam logic [2:0] ST_DATA   = TX_DATA;
    localparam logic [2:0] ST_PARITY = TX_PARITY;
    localparam logic [2:0] ST_STOP   = TX_STOP;
`ifdef UART_TX_BREAK_EN
    localparam logic [2:0] ST_BREAK  = TX_BREAK;
    localparam logic [2:0] ST_MAB    = TX_MAB;
`endif

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              par_bit_q, par_bit_d;
    logic              par_en_q, par_en_d;
    logic              stop2_q, stop2_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;

    logic [DIV_W-1:0]  div_eff;
    logic              idle_ready;
    logic              done_win;
    logic              accept;
    logic              mab_enter;
    logic              cnt_en;
    logic              cnt_load;
    logic [DIV_W-1:0]  cnt_load_val;
    logic              bit_end;

    assign div_eff = (i_baud_div == '0) ? DIV_W'(1) : i_baud_div;

    // A held break request takes the idle slot, so no word is accepted then.
`ifdef UART_TX_BREAK_EN
    assign idle_ready = (state_q == ST_IDLE) && !i_break;
    assign mab_enter  = (state_q == ST_BREAK) && !i_break;
    assign cnt_en     = (state_q != ST_IDLE) && (state_q != ST_BREAK);
`else
    assign idle_ready = (state_q == ST_IDLE);
    assign mab_enter  = 1'b0;
    assign cnt_en     = (state_q != ST_IDLE);
`endif

    // Last clock of the final stop bit; with two stop bits the bit counter
    // holds the stop-bit index.
    assign done_win  = (state_q == ST_STOP) && bit_end &&
                       (!stop2_q || (bit_cnt_q == CNT_W'(1)));
    assign bus.ready = !i_rst && (idle_ready || done_win);
    assign accept    = bus.valid && bus.ready;
    assign o_done    = !i_rst && done_win;

    // Fresh words and the mark-after-break use the live divider; bits inside
    // a frame reuse the value captured when the word was accepted.
    assign cnt_load     = accept || bit_end || mab_enter;
    assign cnt_load_val = (accept || mab_enter) ? div_eff : div_q;

    uart_baud_cnt #(
        .DIV_W (DIV_W)
    ) u_baud_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (cnt_load),
        .i_load_val (cnt_load_val),
        .i_en       (cnt_en),
        .o_bit_end  (bit_end)
    );

    // Frame sequencing: every transition happens on a bit boundary, and the
    // word/configuration capture overrides the per-state updates on accept.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        stop2_d   = stop2_q;
        div_d     = div_q;

        case (state_q)
            ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (i_break) begin
                    state_d = ST_BREAK;
                end else
`endif
                if (accept) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop2_q && (bit_cnt_q == '0)) begin
                        bit_cnt_d = CNT_W'(1);
                    end else begin
                        bit_cnt_d = '0;
                        state_d   = accept ? ST_START : ST_IDLE;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                if (!i_break) begin
                    state_d = ST_MAB;
                end
            end
            ST_MAB: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            shift_d   = bus.data;
            par_bit_d = (^bus.data) ^ (i_par_typ == PAR_ODD);
            par_en_d  = i_par_en;
            stop2_d   = i_stop2;
            div_d     = div_eff;
            bit_cnt_d = '0;
        end
    end

    // The line and busy flag follow the state one clock later, which keeps
    // o_tx glitch-free and gives the one-cycle accept-to-start latency.
    always_comb begin
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_bit_q;
`ifdef UART_TX_BREAK_EN
            ST_BREAK:  tx_d = 1'b0;
`endif
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_q != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            div_q     <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            stop2_q   <= stop2_d;
            div_q     <= div_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign o_tx   = tx_q;
    assign o_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
// Scoreboard bench for uart_tx_frame (DATA_W=8). Each accepted word pushes
// its expected serial frame into a queue; a monitor process pops a frame at
// every start bit and follows the line bit by bit. Build with
// UART_TX_BREAK_EN defined to include the break/MAB sequence.
module tb_uart_tx_frame;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 16;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          cpb;
        int          acc_edge;
    } frame_t;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic [DIV_W-1:0] i_baud_div;
    logic             i_par_en;
    logic             i_par_typ;
    logic             i_stop2;
`ifdef UART_TX_BREAK_EN
    logic             i_break;
`endif
    logic             o_tx;
    logic             o_busy;
    logic             o_done;

    uart_tx_frame_if #(.DATA_W(DATA_W)) bus ();

    uart_tx_frame #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_baud_div (i_baud_div),
        .i_par_en   (i_par_en),
        .i_par_typ  (i_par_typ),
        .i_stop2    (i_stop2),
`ifdef UART_TX_BREAK_EN
        .i_break    (i_break),
`endif
        .bus        (bus),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    int     cyc = 0;
    int     n_checks = 0;
    int     n_errors = 0;
    int     frames_done = 0;
    int     done_seen = 0;
    bit     mon_hold = 1'b0;
    bit     in_frame = 1'b0;
    frame_t exp_q[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected line levels of one frame, built straight from the frame rules.
    function automatic frame_t model(input logic [7:0] d, input int div, input bit pen,
                                     input bit ptyp, input bit s2, input int acc);
        frame_t f;
        int     n = 0;
        f.bits = '1;
        f.bits[n] = 1'b0;
        n++;
        for (int i = 0; i < DATA_W; i++) begin
            f.bits[n] = d[i];
            n++;
        end
        if (pen) begin
            f.bits[n] = (($countones(d) % 2) == 1) ^ ptyp;
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        if (s2) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.nbits    = n;
        f.cpb      = (div == 0) ? 2 : div + 1;
        f.acc_edge = acc;
        return f;
    endfunction

    // Monitor: follows the line one sample per clock on the falling edge.
    initial begin
        frame_t cur;
        int     k = 0;
        int     len = 0;
        int     bad_bits = 0;
        int     bad_busy = 0;
        int     bad_done = 0;
        forever begin
            @(negedge i_clk);
            if (i_rst || mon_hold) begin
                in_frame = 1'b0;
            end else begin
                if (o_done === 1'b1) done_seen++;
                if (!in_frame) begin
                    checkOutput("o_done while idle", 32'(o_done), 32'd0);
                    if (o_tx === 1'b0) begin
                        if (exp_q.size() == 0) begin
                            checkOutput("start bit with empty scoreboard", 32'(o_tx), 32'd1);
                        end else begin
                            cur = exp_q.pop_front();
                            checkOutput("accept-to-start latency", 32'(cyc), 32'(cur.acc_edge + 1));
                            in_frame = 1'b1;
                            k = 0;
                            len = cur.nbits * cur.cpb;
                            bad_bits = 0;
                            bad_busy = 0;
                            bad_done = 0;
                        end
                    end
                end
                if (in_frame) begin
                    if (o_tx !== cur.bits[k / cur.cpb]) bad_bits++;
                    if (o_busy !== 1'b1) bad_busy++;
                    if (o_done !== (k == len - 2)) bad_done++;
                    if (k == len - 2) checkOutput("ready in done window", 32'(bus.ready), 32'd1);
                    if (k == len - 1) begin
                        checkOutput("frame line samples wrong", 32'(bad_bits), 32'd0);
                        checkOutput("frame busy samples wrong", 32'(bad_busy), 32'd0);
                        checkOutput("frame done samples wrong", 32'(bad_done), 32'd0);
                        frames_done++;
                        in_frame = 1'b0;
                    end
                    k++;
                end
            end
        end
    end

    // Offers one word and waits for the handshake; keep leaves i_valid high
    // so the next call forms a back-to-back frame.
    task automatic applyStimulus(input logic [7:0] d, input int div, input bit pen,
                                 input bit ptyp, input bit s2, input bit keep);
        int t = 0;
        bus.data   = d;
        i_baud_div = DIV_W'(div);
        i_par_en   = pen;
        i_par_typ  = ptyp;
        i_stop2    = s2;
        bus.valid  = 1'b1;
        @(negedge i_clk);
        while (bus.ready !== 1'b1 && t < 300) begin
            @(negedge i_clk);
            t++;
        end
        if (bus.ready !== 1'b1) begin
            checkOutput("ready wait timeout", 32'(bus.ready), 32'd1);
            bus.valid = 1'b0;
            return;
        end
        exp_q.push_back(model(d, div, pen, ptyp, s2, cyc + 1));
        @(posedge i_clk);
        #1;
        if (!keep) begin
            bus.valid  = 1'b0;
            bus.data   = 8'($urandom);
            i_baud_div = DIV_W'($urandom_range(0, 7));
            i_par_en   = 1'($urandom);
            i_par_typ  = 1'($urandom);
            i_stop2    = 1'($urandom);
        end
    endtask

    task automatic waitIdle();
        int t = 0;
        @(negedge i_clk);
        while ((exp_q.size() != 0 || in_frame) && t < 1000) begin
            @(negedge i_clk);
            t++;
        end
        checkOutput("scoreboard drain", 32'(exp_q.size()), 32'd0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        bit keep;
        bus.valid  = 1'b0;
        bus.data   = '0;
        i_baud_div = DIV_W'(3);
        i_par_en   = 1'b0;
        i_par_typ  = 1'b0;
        i_stop2    = 1'b0;
`ifdef UART_TX_BREAK_EN
        i_break    = 1'b0;
`endif
        i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("ready during reset", 32'(bus.ready), 32'd0);
        checkOutput("tx during reset", 32'(o_tx), 32'd1);
        checkOutput("busy during reset", 32'(o_busy), 32'd0);
        checkOutput("done during reset", 32'(o_done), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        checkOutput("ready after reset", 32'(bus.ready), 32'd1);
        checkOutput("tx after reset", 32'(o_tx), 32'd1);
        checkOutput("busy after reset", 32'(o_busy), 32'd0);
        checkOutput("done after reset", 32'(o_done), 32'd0);
        @(posedge i_clk);
        #1;

        $display("[TB] directed frames");
        applyStimulus(8'hA5, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        waitIdle();
        applyStimulus(8'h03, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        waitIdle();
        applyStimulus(8'h03, 3, 1'b1, 1'b0, 1'b1, 1'b0);
        waitIdle();
        applyStimulus(8'h1F, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        waitIdle();
        applyStimulus(8'h55, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hAA, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        waitIdle();

        $display("[TB] random frames");
        for (int i = 0; i < 40; i++) begin
            keep = (i != 39) && ($urandom_range(0, 2) == 0);
            applyStimulus(8'($urandom), int'($urandom_range(0, 4)), 1'($urandom),
                          1'($urandom), 1'($urandom), keep);
            if (!keep) begin
                repeat ($urandom_range(0, 20)) @(posedge i_clk);
                #1;
            end
        end
        waitIdle();

        $display("[TB] reset during a data bit");
        applyStimulus(8'hC3, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (17) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        checkOutput("tx after mid-frame reset", 32'(o_tx), 32'd1);
        checkOutput("busy after mid-frame reset", 32'(o_busy), 32'd0);
        checkOutput("ready while reset held", 32'(bus.ready), 32'd0);
        checkOutput("done after mid-frame reset", 32'(o_done), 32'd0);
        @(negedge i_clk);
        checkOutput("tx while reset held", 32'(o_tx), 32'd1);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        exp_q.delete();
        applyStimulus(8'h96, 2, 1'b1, 1'b0, 1'b1, 1'b0);
        waitIdle();

`ifdef UART_TX_BREAK_EN
        begin
            int lows = 0;
            int mabs = 0;
            int s;
            $display("[TB] break and mark-after-break");
            i_baud_div = DIV_W'(9);
            mon_hold = 1'b1;
            i_break = 1'b1;
            for (int n = 0; n <= 62; n++) begin
                @(negedge i_clk);
                s = n - 1;
                if (s >= 1 && s <= 50 && o_tx === 1'b0 && o_busy === 1'b1) lows++;
                if (s >= 51 && s <= 60 && o_tx === 1'b1 && o_busy === 1'b1) mabs++;
                if (s == 30) checkOutput("ready during break", 32'(bus.ready), 32'd0);
                if (s == 59) checkOutput("ready during MAB", 32'(bus.ready), 32'd0);
                if (s == 60) checkOutput("ready after MAB", 32'(bus.ready), 32'd1);
                if (s == 61) checkOutput("busy after MAB", 32'(o_busy), 32'd0);
                if (s == 49) i_break = 1'b0;
            end
            checkOutput("break low cycles", 32'(lows), 32'd50);
            checkOutput("MAB high cycles", 32'(mabs), 32'd10);
            @(posedge i_clk);
            #1;
            mon_hold = 1'b0;
            applyStimulus(8'h5A, 1, 1'b0, 1'b0, 1'b0, 1'b0);
            waitIdle();
        end
`endif

        checkOutput("o_done pulses vs completed frames", 32'(done_seen), 32'(frames_done));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
